prog_ctr: RTL

- Program counter and fetch sequencer for the custom-ISA core; sits directly upstream of the branch-target LUT.
- Drives the LUT pointer from the decoded branch field and consumes the 10-bit Target to redirect fetch.
- Supplies the instruction-memory address (PC) and runs a small run-control FSM (Start/Done handshake) with retired-instruction and cycle counters.

---
 rtl/prog_ctr_if.sv | 32 +++
 rtl/prog_ctr.sv | 111 +++++++++++
 2 files changed

// File: rtl/prog_ctr_if.sv
// Fetch/run-control bundle between the program counter and its environment
// (decode, branch-target LUT, run control).
interface prog_ctr_if #(
  parameter int PC_W  = 10,
  parameter int PTR_W = 5,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stall;
  logic             halt;
  logic             branch_en;
  logic             jump_en;
  logic [PTR_W-1:0] branch_ptr;
  logic [7:0]       lut_addr;
  logic [PC_W-1:0]  lut_target;
  logic [PC_W-1:0]  pc;
  logic             running;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, stall, halt, branch_en, jump_en, branch_ptr, lut_target,
    input  lut_addr, pc, running, done, err, instr_count, cycle_count
  );

  modport slave (
    input  start, stall, halt, branch_en, jump_en, branch_ptr, lut_target,
    output lut_addr, pc, running, done, err, instr_count, cycle_count
  );
endinterface

// File: rtl/prog_ctr.sv
// Program counter and fetch sequencer: walks the PC, redirects through the
// branch-target LUT, and tracks retired instructions and run cycles.
module prog_ctr #(
  parameter int PC_W        = 10,
  parameter int PTR_W       = 5,
  parameter int NUM_TARGETS = 23,
  parameter int START_ADDR  = 0,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  prog_ctr_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] StartPc = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] PcMax   = '1;
  localparam logic [PTR_W:0]  NumTgt  = (PTR_W+1)'(NUM_TARGETS);

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             err_q, err_d;

  logic             redirect;
  logic             bad_ptr;
  logic [CNT_W-1:0] instr_sat;
  logic [CNT_W-1:0] cycle_sat;

  assign redirect  = bus.branch_en | bus.jump_en;
  assign bad_ptr   = {1'b0, bus.branch_ptr} >= NumTgt;
  assign instr_sat = (instr_q == '1) ? instr_q : instr_q + CNT_W'(1);
  assign cycle_sat = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= StartPc;
      instr_q <= '0;
      cycle_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cycle_q <= cycle_d;
      err_q   <= err_d;
    end
  end

  // Stall outranks halt, halt outranks any redirect. A bad pointer or a PC
  // that would run off the top ends the run with Err instead of wrapping,
  // and the LUT output is never loaded in the bad-pointer case.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cycle_d = cycle_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = StartPc;
          instr_d = '0;
          cycle_d = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        cycle_d = cycle_sat;
        if (!bus.stall) begin
          if (bus.halt) begin
            state_d = DONE;
            instr_d = instr_sat;
          end else if (redirect) begin
            if (bad_ptr) begin
              state_d = DONE;
              err_d   = 1'b1;
            end else begin
              pc_d    = bus.lut_target;
              instr_d = instr_sat;
            end
          end else if (pc_q == PcMax) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            instr_d = instr_sat;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.lut_addr    = {{(8-PTR_W){1'b0}}, bus.branch_ptr};
  assign bus.pc          = pc_q;
  assign bus.running     = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.err         = err_q;
  assign bus.instr_count = instr_q;
  assign bus.cycle_count = cycle_q;

endmodule
